// File: rtl/instr_prefetch_reg.sv
// Purpose : instruction prefetch queue feeding a single instruction register (IR).
// Latency : one edge from accepted word to ir when the queue is empty (bypass);
//           otherwise words leave in arrival order as the IR advances.
// Backpressure: in_ready drops when the queue holds DEPTH words or flush is high;
//           it is computed from registered occupancy only, never from stall.
// Ports   : clk/rst_n (async active-low), in_valid/in_ready/in_instr fetch side,
//           stall/flush from decode, ir_valid/ir/opcode decode side, count = queue
//           occupancy (IR not included).
module instr_prefetch_reg #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4,
  parameter int OPW   = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       in_instr,
  input  logic                   stall,
  input  logic                   flush,
  output logic                   ir_valid,
  output logic [WIDTH-1:0]       ir,
  output logic [OPW-1:0]         opcode,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;

  logic push;
  logic advance;
  logic pop;
  logic bypass;
  logic fifo_wr;

  assign in_ready = (count < FULL) && !flush;
  assign push     = in_valid && in_ready;
  // IR takes a new word whenever it is empty or decode is not holding it.
  assign advance  = !ir_valid || !stall;
  assign pop      = advance && (count != '0);
  // Empty queue and IR advancing: the incoming word skips the queue entirely.
  assign bypass   = advance && (count == '0) && push;
  assign fifo_wr  = push && !bypass;

  assign opcode   = ir[WIDTH-1 -: OPW];

  // Queue storage needs no reset: occupancy and pointers define what is live.
  always_ff @(posedge clk) begin
    if (fifo_wr) begin
      mem[wr_ptr] <= in_instr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ir       <= '0;
      ir_valid <= 1'b0;
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
    end else if (flush) begin
      // ir keeps its value; only its validity is dropped.
      ir_valid <= 1'b0;
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
    end else begin
      if (pop) begin
        ir       <= mem[rd_ptr];
        ir_valid <= 1'b1;
        rd_ptr   <= rd_ptr + AW'(1);
      end else if (bypass) begin
        ir       <= in_instr;
        ir_valid <= 1'b1;
      end else if (advance) begin
        ir_valid <= 1'b0;
      end

      if (fifo_wr) begin
        wr_ptr <= wr_ptr + AW'(1);
      end

      // Write and read in the same cycle cancel out on occupancy.
      case ({fifo_wr, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_prefetch_reg.sv
// Purpose : self-checking bench for instr_prefetch_reg; directed scenarios plus
//           randomized traffic compared every cycle against a queue-based model.
// Latency : n/a (testbench).
// Backpressure: driven randomly through stall/flush and in_valid.
module tb_instr_prefetch_reg;

  localparam int W = 16;
  localparam int D = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_instr;
  logic          stall;
  logic          flush;
  logic          ir_valid;
  logic [W-1:0]  ir;
  logic [3:0]    opcode;
  logic [2:0]    count;

  instr_prefetch_reg #(.WIDTH(W), .DEPTH(D), .OPW(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_instr (in_instr),
    .stall    (stall),
    .flush    (flush),
    .ir_valid (ir_valid),
    .ir       (ir),
    .opcode   (opcode),
    .count    (count)
  );

  always #5 clk = ~clk;

  int errs   = 0;
  int checks = 0;
  logic cmp_en = 1'b0;

  // Reference model: a plain queue of accepted-but-not-issued words plus the IR.
  logic [W-1:0] mq[$];
  logic [W-1:0] m_ir;
  logic         m_v;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_ir = '0;
    m_v  = 1'b0;
  endtask

  // One clock edge of behaviour, from the inputs present at that edge.
  task automatic model_step();
    if (flush) begin
      mq.delete();
      m_v = 1'b0;
    end else begin
      if (in_valid && (mq.size() < D)) mq.push_back(in_instr);
      if (!m_v || !stall) begin
        if (mq.size() > 0) begin
          m_ir = mq.pop_front();
          m_v  = 1'b1;
        end else begin
          m_v = 1'b0;
        end
      end
    end
  endtask

  task automatic drive(input logic v, input logic [W-1:0] d, input logic s, input logic f);
    in_valid = v;
    in_instr = d;
    stall    = s;
    flush    = f;
    @(posedge clk);
    model_step();
    #1;
  endtask

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("m_ir_valid", 32'(ir_valid), 32'(m_v));
      chk("m_ir",       32'(ir),       32'(m_ir));
      chk("m_opcode",   32'(opcode),   32'(m_ir[W-1:W-4]));
      chk("m_count",    32'(count),    32'(mq.size()));
      chk("m_in_ready", 32'(in_ready), 32'((mq.size() < D) && !flush));
    end
  end

  initial begin
    logic [W-1:0] saved;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_instr = '0;
    stall    = 1'b0;
    flush    = 1'b0;
    model_reset();

    // Reset state.
    #3;
    chk("rst_ir",       32'(ir),       32'h0);
    chk("rst_ir_valid", 32'(ir_valid), 32'h0);
    chk("rst_count",    32'(count),    32'h0);
    chk("rst_opcode",   32'(opcode),   32'h0);
    chk("rst_in_ready", 32'(in_ready), 32'h1);
    flush = 1'b1;
    #1;
    chk("rst_in_ready_flush", 32'(in_ready), 32'h0);
    flush = 1'b0;
    #8;
    rst_n  = 1'b1;
    cmp_en = 1'b1;

    // First word bypasses straight into ir.
    drive(1'b1, 16'hA123, 1'b0, 1'b0);
    chk("bypass_ir",       32'(ir),       32'hA123);
    chk("bypass_ir_valid", 32'(ir_valid), 32'h1);
    chk("bypass_opcode",   32'(opcode),   32'hA);
    chk("bypass_count",    32'(count),    32'h0);
    chk("model_ir_pin",    32'(m_ir),     32'hA123);

    // Stalled IR: queue fills to DEPTH, then refuses.
    for (int i = 1; i <= 4; i++) drive(1'b1, 16'(i * 16'h1111), 1'b1, 1'b0);
    drive(1'b1, 16'h5555, 1'b1, 1'b0);
    chk("full_count",    32'(count),    32'h4);
    chk("full_in_ready", 32'(in_ready), 32'h0);
    chk("full_ir_held",  32'(ir),       32'hA123);
    for (int i = 1; i <= 4; i++) begin
      drive(1'b0, 16'h0, 1'b0, 1'b0);
      chk("drain_ir",    32'(ir),    32'(i * 16'h1111));
      chk("drain_count", 32'(count), 32'(4 - i));
    end
    // Empty queue, nothing offered: IR goes invalid but keeps its value.
    drive(1'b0, 16'h0, 1'b0, 1'b0);
    chk("empty_ir_valid", 32'(ir_valid), 32'h0);
    chk("empty_ir_hold",  32'(ir),       32'h4444);

    // Steady state with two queued words across pointer wrap.
    drive(1'b1, 16'h5000, 1'b1, 1'b0);
    drive(1'b1, 16'h5001, 1'b1, 1'b0);
    drive(1'b1, 16'h5002, 1'b1, 1'b0);
    chk("pre_wrap_count", 32'(count), 32'h2);
    for (int j = 0; j < 12; j++) begin
      drive(1'b1, 16'(16'h5003 + j), 1'b0, 1'b0);
      chk("wrap_ir",    32'(ir),    32'(16'h5001 + j));
      chk("wrap_count", 32'(count), 32'h2);
    end

    // Flush dominates a push while stalled with three queued words.
    drive(1'b1, 16'h6000, 1'b1, 1'b0);
    chk("preflush_count", 32'(count), 32'h3);
    saved = ir;
    drive(1'b1, 16'h6001, 1'b1, 1'b1);
    chk("flush_count",    32'(count),    32'h0);
    chk("flush_ir_valid", 32'(ir_valid), 32'h0);
    chk("flush_ir",       32'(ir),       32'(saved));
    chk("flush_in_ready", 32'(in_ready), 32'h0);
    drive(1'b0, 16'h0, 1'b0, 1'b0);
    chk("postflush_ir_valid", 32'(ir_valid), 32'h0);
    chk("postflush_count",    32'(count),    32'h0);

    // Asynchronous reset between edges with three queued words.
    drive(1'b1, 16'h7000, 1'b1, 1'b0);
    for (int i = 1; i <= 3; i++) drive(1'b1, 16'(16'h7000 + i), 1'b1, 1'b0);
    chk("prerst_count", 32'(count), 32'h3);
    in_valid = 1'b0;
    stall    = 1'b0;
    #1;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("arst_ir",       32'(ir),       32'h0);
    chk("arst_ir_valid", 32'(ir_valid), 32'h0);
    chk("arst_count",    32'(count),    32'h0);
    chk("arst_opcode",   32'(opcode),   32'h0);
    chk("arst_in_ready", 32'(in_ready), 32'h1);
    #1;
    rst_n = 1'b1;
    drive(1'b1, 16'h7ABC, 1'b0, 1'b0);
    chk("postrst_ir",       32'(ir),       32'h7ABC);
    chk("postrst_ir_valid", 32'(ir_valid), 32'h1);
    chk("postrst_count",    32'(count),    32'h0);

    // Randomized traffic with phases of different stall density.
    for (int n = 0; n < 3000; n++) begin
      int stall_pct;
      stall_pct = (n / 500) * 18;
      drive($urandom_range(0, 3) != 0,
            16'($urandom),
            $urandom_range(0, 99) < stall_pct,
            $urandom_range(0, 31) == 0);
    end

    @(negedge clk);
    cmp_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/instr_prefetch_reg.md
INSTR_PREFETCH_REG -- requirements
Module: instr_prefetch_reg

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, meaning instruction word width in bits (WIDTH >= 8).
REQ-002 The block SHALL have parameter DEPTH, default 4, meaning prefetch FIFO entries (power of two, >= 2).
REQ-003 The block SHALL have parameter OPW, default 4, meaning opcode field width, taken from the MSBs of the word (OPW < WIDTH).
REQ-004 The block SHALL have one clock; reset is asynchronous and active-low (ports clk and rst_n).
REQ-005 The block SHALL have port clk, input, 1 bit: rising-edge clock for all state.
REQ-006 The block SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-007 The block SHALL have port in_valid, input, 1 bit: fetch word offered.
REQ-008 The block SHALL have port in_ready, output, 1 bit: block accepts the word this cycle.
REQ-009 The block SHALL have port in_instr, input, WIDTH bits: fetched instruction.
REQ-010 The block SHALL have port stall, input, 1 bit: decode stage holds the current IR.
REQ-011 The block SHALL have port flush, input, 1 bit: discard all queued and held instructions.
REQ-012 The block SHALL have port ir_valid, output, 1 bit: ir holds a live instruction.
REQ-013 The block SHALL have port ir, output, WIDTH bits: instruction register.
REQ-014 The block SHALL have port opcode, output, OPW bits: ir[WIDTH-1:WIDTH-OPW], combinational from ir.
REQ-015 The block SHALL have port count, output, $clog2(DEPTH)+1 bits: FIFO occupancy, IR excluded.

Function
REQ-016 Push SHALL occur on a rising edge when in_valid && in_ready.
REQ-017 in_ready SHALL equal (count < DEPTH) && !flush, registered-state only, with no combinational path from stall.
REQ-018 Full FIFO with a same-cycle IR advance SHALL still deassert in_ready; no push while full.
REQ-019 The IR SHALL advance on a rising edge when !ir_valid || !stall.
REQ-020 On advance with count > 0, ir SHALL load the FIFO head, ir_valid=1, count decrements, unless a push occurs in the same cycle.
REQ-021 On advance with count == 0 and a push in the same cycle, the word SHALL bypass into ir (ir_valid=1, count stays 0), giving one-cycle latency.
REQ-022 On advance with count == 0 and no push, ir_valid SHALL go to 0 and ir SHALL keep its old value.
REQ-023 With ir_valid && stall, ir and ir_valid SHALL hold; pushes continue into the FIFO until full.
REQ-024 Simultaneous push and pop with 0 < count < DEPTH SHALL leave count unchanged and preserve FIFO order.
REQ-025 FIFO read/write pointers SHALL wrap modulo DEPTH; count SHALL never exceed DEPTH or underflow.
REQ-026 flush SHALL dominate push, advance and stall: next edge count=0, pointers=0, ir_valid=0, ir unchanged.
REQ-027 Instruction order out of ir SHALL equal accepted order, with no duplication or loss except via flush.

Reset
REQ-028 While rst_n=0, regardless of clk, the block SHALL force ir=0, ir_valid=0, count=0, pointers=0, giving opcode=0 and in_ready=1 (in_ready=0 only when flush=1).
REQ-029 Reset mid-operation SHALL discard all FIFO contents; the first edge after rst_n rises SHALL behave as from empty.

Verification
REQ-030 The bench SHALL cover this scenario: after reset, push 0xA123 with stall=0 -> next edge ir=0xA123, ir_valid=1, opcode=0xA, count=0.
REQ-031 The bench SHALL cover this scenario: stall=1 with ir_valid=1, push 0x1111..0x4444 -> count=4, in_ready=0; then stall=0 -> ir shows 0x1111, 0x2222, 0x3333, 0x4444 on successive edges.
REQ-032 The bench SHALL cover this scenario: count=2, stall=0, push every cycle -> count stays 2 and output order is preserved across pointer wrap (>= 10 words).
REQ-033 The bench SHALL cover this scenario: count=3, ir_valid=1, flush=1 with in_valid=1 -> next edge count=0, ir_valid=0, word not accepted, ir value unchanged.
REQ-034 The bench SHALL cover this scenario: FIFO empty, stall=0, no push -> ir_valid drops to 0 after the last word, ir holds the last value.
REQ-035 The bench SHALL cover this scenario: rst_n pulsed low between edges with count=3 -> outputs clear immediately; the next push reaches ir with one-cycle latency.
